// File: rtl/uart_pkg.sv
// uart_pkg: register map, bit indices, state encodings and constants for uart_mmio
package uart_pkg;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_DIV = 2'd3;
  localparam int S_RX_EMPTY = 0, S_RX_FULL = 1, S_TX_EMPTY = 2, S_TX_FULL = 3, S_TX_BUSY = 4;
  localparam int S_OVR = 5, S_FERR = 6, S_PERR = 7;
  localparam int C_STOP2 = 2, C_RX_IRQ = 3, C_TX_IRQ = 4, C_LOOP = 5;
  localparam logic [15:0] DIV_MIN = 16'd4;
  typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10, PAR_NONE2 = 2'b11} parity_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  function automatic logic par_en(parity_t p);
    return p == PAR_EVEN || p == PAR_ODD;
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO; push on full succeeds only alongside a pop, pop on empty is ignored
module uart_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];
  // pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage, no reset needed
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: register-mapped UART with FIFOs, runtime divisor, parity, stop bits, flags and irq
module uart_mmio #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int DIV_RESET = 521
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  import uart_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [3:0] LAST = 4'(DATA_W - 1);
  logic [5:0] ctrl;
  logic [15:0] div;
  logic ovr, ferr, perr, set_ovr, set_ferr, set_perr;
  logic [2:0] clr;
  logic tx_push, tx_pop, tx_empty, tx_full, rx_push, rx_pop, rx_empty, rx_full, tx_busy;
  logic [DATA_W-1:0] tx_dout, rx_dout;
  logic [CW-1:0] tx_count, rx_count;
  logic [31:0] status;
  logic rx_s1, rx_s2, unused_ok;
  tx_state_t tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [3:0] tx_idx, tx_idx_n;
  logic [DATA_W-1:0] tx_sh, tx_sh_n;
  logic tx_pen, tx_pen_n, tx_pb, tx_pb_n, tx_stop2, tx_stop2_n, tx_end;
  rx_state_t rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [3:0] rx_idx, rx_idx_n;
  logic [DATA_W-1:0] rx_sh, rx_sh_n;
  logic rx_pen, rx_pen_n, rx_odd, rx_odd_n, rx_pb, rx_pb_n, rx_hit;

  uart_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(wdata[DATA_W-1:0]),
    .dout(tx_dout), .count(tx_count), .empty(tx_empty), .full(tx_full));
  uart_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_sh),
    .dout(rx_dout), .count(rx_count), .empty(rx_empty), .full(rx_full));

  assign tx_push = wr && addr == A_DATA;
  assign rx_pop = rd && addr == A_DATA;
  assign clr = (wr && addr == A_STATUS) ? wdata[7:5] : 3'd0;
  assign tx_busy = tx_state != TX_IDLE;
  assign status = {8'd0, 8'(tx_count), 8'(rx_count), perr, ferr, ovr, tx_busy, tx_full, tx_empty, rx_full, rx_empty};
  assign irq = (ctrl[C_RX_IRQ] & (~rx_empty | ovr | ferr | perr)) | (ctrl[C_TX_IRQ] & tx_empty & ~tx_busy);
  assign unused_ok = ^wdata[31:16];
  assign tx_end = tx_cnt == tx_div - 16'd1;
  assign rx_hit = rx_cnt == 16'd0;

  // control registers and sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ctrl <= '0;
      div <= 16'(DIV_RESET);
      {perr, ferr, ovr} <= '0;
    end else begin
      if (wr && addr == A_CTRL) ctrl <= wdata[5:0];
      if (wr && addr == A_DIV) div <= wdata[15:0] < DIV_MIN ? DIV_MIN : wdata[15:0];
      {perr, ferr, ovr} <= {set_perr, set_ferr, set_ovr} | ({perr, ferr, ovr} & ~clr);
    end

  // registered read port; DATA read of an empty FIFO returns zero
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (rd)
      rdata <= addr == A_DATA ? (rx_empty ? 32'd0 : 32'(rx_dout)) :
               addr == A_STATUS ? status : addr == A_CTRL ? 32'(ctrl) : 32'(div);

  // two-flop synchroniser on the serial input, fed from tx in loopback
  always_ff @(posedge clk or posedge rst)
    if (rst) {rx_s2, rx_s1} <= 2'b11;
    else {rx_s2, rx_s1} <= {rx_s1, ctrl[C_LOOP] ? tx : rx};

  // TX next state; frame settings are captured whenever a character is popped
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n = tx_end ? 16'd0 : tx_cnt + 16'd1;
    tx_idx_n = tx_idx;
    tx_sh_n = tx_sh;
    tx_div_n = tx_div;
    tx_pen_n = tx_pen;
    tx_pb_n = tx_pb;
    tx_stop2_n = tx_stop2;
    tx_pop = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = 16'd0;
        tx_pop = ~tx_empty;
      end
      TX_START: if (tx_end) begin
        tx_state_n = TX_DATA;
        tx_idx_n = 4'd0;
      end
      TX_DATA: if (tx_end) begin
        tx_sh_n = tx_sh >> 1;
        tx_idx_n = tx_idx == LAST ? 4'd0 : tx_idx + 4'd1;
        if (tx_idx == LAST) tx_state_n = tx_pen ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: if (tx_end) tx_state_n = TX_STOP;
      TX_STOP: if (tx_end) begin
        if (tx_stop2 && tx_idx == 4'd0) tx_idx_n = 4'd1;
        else if (!tx_empty) tx_pop = 1'b1;
        else tx_state_n = TX_IDLE;
      end
      default: tx_state_n = TX_IDLE;
    endcase
    if (tx_pop) begin
      tx_state_n = TX_START;
      tx_cnt_n = 16'd0;
      tx_idx_n = 4'd0;
      tx_sh_n = tx_dout;
      tx_div_n = div;
      tx_pen_n = par_en(parity_t'(ctrl[1:0]));
      tx_pb_n = ^tx_dout ^ (ctrl[1:0] == PAR_ODD);
      tx_stop2_n = ctrl[C_STOP2];
    end
  end

  // TX state register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt <= '0;
      tx_div <= '0;
      tx_idx <= '0;
      tx_sh <= '0;
      {tx_pen, tx_pb, tx_stop2} <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt <= tx_cnt_n;
      tx_div <= tx_div_n;
      tx_idx <= tx_idx_n;
      tx_sh <= tx_sh_n;
      {tx_pen, tx_pb, tx_stop2} <= {tx_pen_n, tx_pb_n, tx_stop2_n};
    end

  // serial output follows the current state one cycle later; idles high
  always_ff @(posedge clk or posedge rst)
    if (rst) tx <= 1'b1;
    else tx <= tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_sh[0] : tx_state == TX_PARITY ? tx_pb : 1'b1;

  // RX next state; down-counter reaches zero at each mid-bit sample point
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n = rx_hit ? rx_div - 16'd1 : rx_cnt - 16'd1;
    rx_idx_n = rx_idx;
    rx_sh_n = rx_sh;
    rx_div_n = rx_div;
    rx_pen_n = rx_pen;
    rx_odd_n = rx_odd;
    rx_pb_n = rx_pb;
    rx_push = 1'b0;
    set_ovr = 1'b0;
    set_ferr = 1'b0;
    set_perr = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = (div >> 1) - 16'd1;
        if (!rx_s2) begin
          rx_state_n = RX_START;
          rx_div_n = div;
          rx_pen_n = par_en(parity_t'(ctrl[1:0]));
          rx_odd_n = ctrl[1:0] == PAR_ODD;
        end
      end
      RX_START: if (rx_hit) begin
        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        rx_idx_n = 4'd0;
      end
      RX_DATA: if (rx_hit) begin
        rx_sh_n = {rx_s2, rx_sh[DATA_W-1:1]};
        rx_idx_n = rx_idx + 4'd1;
        if (rx_idx == LAST) rx_state_n = rx_pen ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_hit) begin
        rx_pb_n = rx_s2;
        rx_state_n = RX_STOP;
      end
      RX_STOP: if (rx_hit) begin
        rx_state_n = RX_IDLE;
        set_ferr = ~rx_s2;
        set_perr = rx_s2 & rx_pen & ((^rx_sh ^ rx_odd) != rx_pb);
        set_ovr = rx_s2 & ~set_perr & rx_full & ~rx_pop;
        rx_push = rx_s2 & ~set_perr & ~set_ovr;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt <= '0;
      rx_div <= '0;
      rx_idx <= '0;
      rx_sh <= '0;
      {rx_pen, rx_odd, rx_pb} <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt <= rx_cnt_n;
      rx_div <= rx_div_n;
      rx_idx <= rx_idx_n;
      rx_sh <= rx_sh_n;
      {rx_pen, rx_odd, rx_pb} <= {rx_pen_n, rx_odd_n, rx_pb_n};
    end
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench for uart_mmio; read and tx-bit expectations are queued and checked by a monitor
module tb_uart_mmio;
  import uart_pkg::*;
  logic clk = 1'b0, rst = 1'b1, wr = 1'b0, rd = 1'b0, rx = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic tx, irq;
  logic rd_v = 1'b0;
  int pass_n = 0, total_n = 0;
  typedef struct {string name; logic [31:0] val; bit chk_irq; logic irqv;} rd_exp_t;
  rd_exp_t rq[$];
  rd_exp_t e;
  logic txq[$];

  uart_mmio #(.DATA_W(8), .DEPTH(4), .DIV_RESET(521)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .wdata(wdata),
    .rdata(rdata), .rx(rx), .tx(tx), .irq(irq));

  always #5 clk = ~clk;
  always @(posedge clk) rd_v <= rd;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (rd_v) begin
      if (rq.size() == 0) begin
        total_n++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", rdata);
      end else begin
        e = rq.pop_front();
        check(e.name, rdata, e.val);
        if (e.chk_irq) check({e.name, "_irq"}, 32'(irq), 32'(e.irqv));
      end
    end
    if (txq.size() > 0) check("tx_bit", 32'(tx), 32'(txq.pop_front()));
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d);
    wr = w; rd = r; addr = a; wdata = d;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic wreg(input logic [1:0] a, input logic [31:0] d);
    bus(1'b1, 1'b0, a, d);
  endtask

  task automatic rreg(input logic [1:0] a, input string name, input logic [31:0] v,
                      input bit ci = 1'b0, input logic iv = 1'b0);
    rq.push_back('{name, v, ci, iv});
    bus(1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic push_frame(input logic [7:0] d, input int dv);
    repeat (dv) txq.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (dv) txq.push_back(d[i]);
    repeat (dv) txq.push_back(1'b1);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    rx = 1'b0; idle(4);
    for (int i = 0; i < 8; i++) begin rx = d[i]; idle(4); end
    rx = stop; idle(4);
    rx = 1'b1;
  endtask

  task automatic wait_tx();
    for (int i = 0; i < 400 && txq.size() > 0; i++) @(posedge clk);
    #1;
    if (txq.size() > 0) begin
      total_n++;
      $display("FAIL tx_drain: %0d bits still pending, expected 0", txq.size());
      txq.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    idle(2);
    rreg(A_STATUS, "reset_status", 32'h05);
    rreg(A_CTRL, "reset_ctrl", 32'h0);
    rreg(A_DIV, "reset_div", 32'd521);
    rreg(A_DATA, "empty_data", 32'h0);
    wreg(A_DIV, 32'd1);
    rreg(A_DIV, "div_clamp", 32'd4);
    // single frame 0xA5 at DIV=4
    wreg(A_DATA, 32'hA5);
    txq.push_back(1'b1); txq.push_back(1'b1);
    push_frame(8'hA5, 4);
    idle(40);
    rreg(A_STATUS, "tx_busy_end", 32'h15);
    rreg(A_STATUS, "tx_idle", 32'h05);
    wait_tx();
    // loopback with even parity
    wreg(A_CTRL, 32'h21);
    wreg(A_DATA, 32'h3C);
    idle(70);
    rreg(A_DATA, "loop_data", 32'h3C);
    rreg(A_STATUS, "loop_status", 32'h05);
    // framing error
    wreg(A_CTRL, 32'h08);
    send_rx(8'h55, 1'b0);
    idle(20);
    rreg(A_STATUS, "ferr_status", 32'h45, 1'b1, 1'b1);
    wreg(A_STATUS, 32'h40);
    rreg(A_STATUS, "ferr_clear", 32'h05, 1'b1, 1'b0);
    // overrun with DEPTH=4
    wreg(A_CTRL, 32'h0);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    send_rx(8'h33, 1'b1);
    send_rx(8'h44, 1'b1);
    send_rx(8'h55, 1'b1);
    idle(20);
    rreg(A_STATUS, "ovr_status", 32'h426);
    rreg(A_DATA, "ovr_rd0", 32'h11);
    rreg(A_DATA, "ovr_rd1", 32'h22);
    rreg(A_DATA, "ovr_rd2", 32'h33);
    rreg(A_DATA, "ovr_rd3", 32'h44);
    rreg(A_DATA, "ovr_rd4", 32'h00);
    rreg(A_STATUS, "ovr_after", 32'h25);
    wreg(A_STATUS, 32'h20);
    rreg(A_STATUS, "ovr_clear", 32'h05);
    // divisor change mid-frame applies to the next frame
    wreg(A_DATA, 32'hF0);
    txq.push_back(1'b1); txq.push_back(1'b1);
    push_frame(8'hF0, 4);
    push_frame(8'h0F, 8);
    wreg(A_DATA, 32'h0F);
    idle(8);
    wreg(A_DIV, 32'd8);
    rreg(A_DIV, "div8", 32'd8);
    wait_tx();
    idle(5);
    // reset mid-frame
    wreg(A_DATA, 32'h00);
    wreg(A_DATA, 32'h00);
    wreg(A_DATA, 32'h00);
    rreg(A_STATUS, "busy_status", 32'h0002_0011);
    idle(5);
    check("pre_rst_tx", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_tx_async", 32'(tx), 32'd1);
    idle(2);
    rst = 1'b0;
    idle(2);
    rreg(A_STATUS, "post_rst_status", 32'h05);
    rreg(A_CTRL, "post_rst_ctrl", 32'h0);
    rreg(A_DIV, "post_rst_div", 32'd521);
    idle(3);
    if (rq.size() != 0) begin
      total_n++;
      $display("FAIL read_drain: %0d reads unanswered, expected 0", rq.size());
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
